// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding constants for the instruction encoder/loader.
// Holds the instruction-class codes, the nine major opcodes (the same set the
// main decoder recognises), the canonical NOP word and the loader FSM states.
package riscv_enc_pkg;

    // Instruction classes carried on the descriptor stream; 9..15 are illegal.
    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_I_ALU  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;

    // Major opcodes.
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer.
// Ports:
//   i_class            instruction class code
//   i_rd/i_rs1/i_rs2   register indices
//   i_funct3, i_f7b5   funct3 and funct7 bit 5
//   i_imm              sign-extended immediate (U-type: upper 20 bits used)
//   o_word             packed 32-bit instruction (NOP for illegal classes)
//   o_illegal          class code is not one of the nine legal classes
module instr_field_packer
    import riscv_enc_pkg::*;
(
    input  logic [3:0]  i_class,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_f7b5,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [11:0] w_imm_i;

    // Shift-immediate forms carry funct7 in the upper immediate bits.
    always_comb begin
        w_imm_i = i_imm[11:0];
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
            w_imm_i = {1'b0, i_f7b5, 5'b0, i_imm[4:0]};
        end
    end

    always_comb begin
        o_word    = NOP_WORD;
        o_illegal = 1'b0;
        case (i_class)
            CLS_R:
                o_word = {1'b0, i_f7b5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OPC_R};
            CLS_I_ALU:
                o_word = {w_imm_i, i_rs1, i_funct3, i_rd, OPC_I_ALU};
            CLS_LOAD:
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
            CLS_STORE:
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
            CLS_BRANCH:
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], OPC_BRANCH};
            CLS_JAL:
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
            CLS_JALR:
                o_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR};
            CLS_LUI:
                o_word = {i_imm[31:12], i_rd, OPC_LUI};
            CLS_AUIPC:
                o_word = {i_imm[31:12], i_rd, OPC_AUIPC};
            default: begin
                o_word    = NOP_WORD;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: encodes descriptor-stream entries into
// RV32I words and writes them to consecutive word addresses from 0.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               begin a load session (IDLE or DONE only)
//   in_valid/in_ready   descriptor handshake
//   in_class..in_last   descriptor fields
//   imem_we/addr/wdata  registered instruction-memory write port
//   count               words written this session
//   done                session finished
//   err                 sticky illegal-class / overflow flag
module imem_program_loader
    import riscv_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    state_t              r_state;
    logic [ADDR_W:0]     r_count;
    logic                r_err;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic [31:0]         w_word;
    logic                w_illegal;
    logic                w_ready;

    instr_field_packer u_packer (
        .i_class   (in_class),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_funct3  (in_funct3),
        .i_f7b5    (in_f7b5),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // count never exceeds DEPTH, so its top bit alone marks a full memory.
    assign w_ready = (r_state == StLoad) && !r_count[ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_count <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state <= StLoad;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                StLoad: begin
                    if (in_valid && w_ready) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count[ADDR_W-1:0];
                        r_wdata <= w_word;
                        r_count <= r_count + CNT_ONE;
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end
                        if (in_last) begin
                            r_state <= StDone;
                        end else if (&r_count[ADDR_W-1:0]) begin
                            // Last free word consumed without an end marker.
                            r_state <= StDone;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = (r_state == StDone);
    assign err        = r_err;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: stimulus pushes expected writes,
// negedge monitors pop and compare whenever a DUT asserts imem_we.
module tb_imem_program_loader;

    localparam int unsigned AW  = 10;
    localparam int unsigned AW2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared descriptor fields
    logic [3:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [31:0] in_imm;
    logic        in_last;

    // DUT A (default depth)
    logic          start, in_valid, in_ready, imem_we, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    // DUT B (depth 4)
    logic           start2, in_valid2, in_ready2, imem_we2, done2, err2;
    logic [AW2-1:0] imem_addr2;
    logic [31:0]    imem_wdata2;
    logic [AW2:0]   count2;

    imem_program_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err(err)
    );

    imem_program_loader #(.ADDR_W(AW2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .count(count2), .done(done2), .err(err2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] q_addr[$], q_data[$], q2_addr[$], q2_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (q_data.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                chk("wr_addr", 32'(imem_addr), q_addr.pop_front());
                chk("wr_data", imem_wdata, q_data.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (imem_we2 === 1'b1) begin
            if (q2_data.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write2: got addr 0x%0h data 0x%08h expected no write",
                         imem_addr2, imem_wdata2);
            end else begin
                chk("wr2_addr", 32'(imem_addr2), q2_addr.pop_front());
                chk("wr2_data", imem_wdata2, q2_data.pop_front());
            end
        end
    end

    task automatic set_fields(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                              input logic [31:0] imm, input logic last);
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_f7b5   = f7;
        in_imm    = imm;
        in_last   = last;
    endtask

    // One descriptor into DUT A; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word, input logic [31:0] exp_addr);
        int k = 0;
        set_fields(cls, rd, rs1, rs2, f3, f7, imm, last);
        q_addr.push_back(exp_addr);
        q_data.push_back(exp_word);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k == 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0; in_valid = 1'b0;
        start2 = 1'b0; in_valid2 = 1'b0;
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 0);

        // Program: add, sw, beq, jal, lui(last)
        pulse_start();
        chk("load_in_ready", 32'(in_ready), 1);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 1'b0, 32'h002081B3, 0);
        chk("count_after_add", 32'(count), 1);
        send(4'd3, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 32'd8, 1'b0, 32'h00512423, 1);
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4, 1'b0, 32'hFE208EE3, 2);
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 1'b0, 32'h008000EF, 3);
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345ABC, 1'b1, 32'h123452B7, 4);
        chk("last_we", 32'(imem_we), 1);
        chk("last_done", 32'(done), 1);
        chk("last_in_ready", 32'(in_ready), 0);
        chk("last_count", 32'(count), 5);
        chk("last_err", 32'(err), 0);

        // Illegal class, sticky err, srai
        pulse_start();
        chk("restart_done", 32'(done), 0);
        chk("restart_count", 32'(count), 0);
        send(4'd12, 5'd3, 5'd1, 5'd2, 3'b111, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000013, 0);
        chk("illegal_err", 32'(err), 1);
        send(4'd1, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd3, 1'b1, 32'h40315093, 1);
        chk("err_sticky", 32'(err), 1);
        chk("srai_done", 32'(done), 1);
        pulse_start();
        chk("start_clears_err", 32'(err), 0);

        // Reset mid-stream: lw x6,4(x1); jalr x0,0(x1) with funct3 forced to 0
        send(4'd2, 5'd6, 5'd1, 5'd0, 3'b010, 1'b0, 32'd4, 1'b0, 32'h0040A303, 0);
        send(4'd6, 5'd0, 5'd1, 5'd0, 3'b111, 1'b0, 32'd0, 1'b0, 32'h00008067, 1);
        chk("pre_rst_count", 32'(count), 2);
        set_fields(4'd0, 5'd7, 5'd7, 5'd7, 3'b000, 1'b0, 32'd0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_we", 32'(imem_we), 0);
        chk("midrst_addr", 32'(imem_addr), 0);
        chk("midrst_wdata", imem_wdata, 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_done", 32'(done), 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 1'b0, 32'h002081B3, 0);
        chk("post_rst_count", 32'(count), 1);

        // Overflow on the 4-word DUT: addi x1,x0,k for k=1..5, no in_last
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            q2_addr.push_back(32'(k - 1));
            q2_data.push_back((32'(k) << 20) | 32'h00000093);
        end
        in_valid2 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_fields(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'(k), 1'b0);
            @(posedge clk);
            #1;
        end
        chk("ovf_we", 32'(imem_we2), 1);
        chk("ovf_in_ready", 32'(in_ready2), 0);
        chk("ovf_done", 32'(done2), 1);
        chk("ovf_err", 32'(err2), 1);
        chk("ovf_count", 32'(count2), 4);
        set_fields(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0);
        @(posedge clk);
        #1;
        chk("ovf_5th_not_taken", 32'(count2), 4);
        in_valid2 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q_data.size() + q2_data.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Sequential instruction encoder and program loader: the write-side counterpart of the core's main decoder. It accepts symbolic RV32I instruction descriptors over a valid/ready stream. It packs each descriptor into a 32-bit machine word using exactly the opcode set the decoder recognises. It then writes the words to consecutive instruction-memory word addresses from 0, so test programs and boot images can be built in hardware and run by the core.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width; capacity `DEPTH = 2**ADDR_W` words.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load session (honoured only in IDLE or DONE).
- `in_valid`  in  1  descriptor valid.
- `in_ready`  out  1  loader can accept a descriptor.
- `in_class`  in  4  instruction class (see Operation).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3 field.
- `in_f7b5`  in  1  funct7 bit 5 (SUB/SRA/SRAI).
- `in_imm`  in  32  immediate, sign-extended byte value; for LUI/AUIPC, the full value with bits 11:0 ignored.
- `in_last`  in  1  descriptor is the final one of the program.
- `imem_we`  out  1  write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  words written this session.
- `done`  out  1  session finished (level).
- `err`  out  1  sticky: illegal class seen or memory overflowed.

## Operation
- Classes and opcodes:
  - 0 R `0110011`
  - 1 I-ALU `0010011`
  - 2 LOAD `0000011`
  - 3 STORE `0100011`
  - 4 BRANCH `1100011`
  - 5 JAL `1101111`
  - 6 JALR `1100111`
  - 7 LUI `0110111`
  - 8 AUIPC `0010111`
  - 9–15 illegal.
- Field packing:
  - R: `{1'b0,f7b5,5'b0,rs2,rs1,funct3,rd,op}`.
  - I-ALU/LOAD: `imm[11:0]` in [31:20]. For I-ALU with funct3 `001` or `101`, the word is `{1'b0,f7b5,5'b0,imm[4:0]}` in [31:20].
  - JALR: the I-type format with funct3 forced to `000`.
  - S: `imm[11:5]` in [31:25], `imm[4:0]` in [11:7].
  - B: `imm[12|10:5]` in [31:25], `imm[4:1|11]` in [11:7]; `imm[0]` is ignored.
  - J: `imm[20|10:1|11|19:12]` in [31:12]; `imm[0]` is ignored.
  - U: `imm[31:12]` in [31:12].
- An illegal class writes the NOP `0x00000013` and sets `err`.
- FSM states are IDLE, LOAD and DONE.
  - IDLE: `in_ready`=0. `start` moves to LOAD and clears `count` and `err`.
  - LOAD: `in_ready = (count < DEPTH)`. On each accepted descriptor (`in_valid && in_ready`), one word is written at `count` and `count` increments. Accepting with `in_last`=1 moves to DONE. Accepting the DEPTH-th word without `in_last` moves to DONE and sets `err`. `start` is ignored in LOAD.
  - DONE: `done`=1 and `in_ready`=0. `start` begins a new session exactly as from IDLE.
- Reset mid-session aborts the session with no partial write completed. All state clears.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `count`=0, `done`=0, `err`=0; state is IDLE.
- Encoding is combinational into a single output register. For an accept at edge N, `imem_we`/`imem_addr`/`imem_wdata` are valid during cycle N→N+1.
- `imem_we` is high for exactly one cycle per accepted descriptor. Throughput is one word per cycle.
- `count`, the FSM state and `err` update at the same edge as the accept. `done` rises in the same cycle as the final `imem_we`.
- `in_ready` is a registered-state function only and never depends on `in_valid`.

## Structure
- Package `riscv_enc_pkg`: class codes, the nine 7-bit opcode constants, `NOP_WORD = 32'h0000_0013`, and FSM state encoding. The main decoder uses the same opcode constants.
- Sub-module `instr_field_packer`: purely combinational; takes class, fields and immediate, and returns the word plus an illegal flag.
- `imem_program_loader` holds the FSM, the counter and the output register.

## Test plan
- `add x3,x1,x2` (class 0, f3=0, f7b5=0) → `imem_wdata=0x002081B3`, addr 0, `count`=1.
- `sw x5,8(x2)` (class 3, f3=010, imm=8) → `0x00512423`; `beq x1,x2,-4` (class 4, imm=-4) → `0xFE208EE3`, addrs 1 and 2.
- `jal x1,8` → `0x008000EF`; `lui x5` with imm=`0x12345000` → `0x123452B7`; then `in_last` → `done`=1, `in_ready`=0 in the same cycle as the last `imem_we`.
- Class 12 → `imem_wdata=0x00000013`, `err`=1 and stays set until the next `start`.
- `ADDR_W=2`, 5 back-to-back descriptors with no `in_last` → 4 writes at addrs 0–3, `in_ready` low after the 4th accept, `done`=1, `err`=1, 5th descriptor not consumed.
- Assert `rst`=0 mid-stream after 2 accepts → all outputs 0 immediately; after release, `start` restarts at addr 0.
